// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding
// and the default data-memory wait timeout.
package hazard_pkg;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_MEM_WAIT = 2'd1,
        HZ_ERROR    = 2'd2
    } hz_state_t;

    localparam int unsigned MEM_TIMEOUT_DEFAULT = 200;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter used for the hazard controller's performance
// statistics. Synchronous active-low reset; holds at all-ones once full.
module hazard_perf_cnt #(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    output logic [PERF_W-1:0] count
);

    localparam logic [PERF_W-1:0] CNT_ONE = 1;

    logic [PERF_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + CNT_ONE;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, data-memory wait stalls with
// timeout, and taken-branch flushes. Optional counters: HAZARD_CTRL_PERF_EN.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int          REG_AW      = 5,
    parameter int          TIMEOUT_W   = 8,
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
    parameter int          PERF_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_memread,
    input  logic              ex_br_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              stall_pc,
    output logic              stall_ifid,
    output logic              stall_idex,
    output logic              stall_exmem,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic              mem_err,
    output logic [PERF_W-1:0] perf_lu,
    output logic [PERF_W-1:0] perf_mw,
    output logic [PERF_W-1:0] perf_fl
);

    localparam logic [TIMEOUT_W-1:0] TCNT_ONE   = 1;
    localparam logic [TIMEOUT_W-1:0] TCNT_LIMIT = TIMEOUT_W'(MEM_TIMEOUT);

    hz_state_t            state_reg, state_next;
    logic [TIMEOUT_W-1:0] tcnt_reg, tcnt_next;
    logic                 pend_fl_reg, pend_fl_next;
    logic                 mem_err_reg, mem_err_next;

    logic mw;
    logic lu;

    assign mw = mem_req && !mem_ready;
    assign lu = ex_memread && (ex_rd != '0) &&
                ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= HZ_RUN;
            tcnt_reg    <= '0;
            pend_fl_reg <= 1'b0;
            mem_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            tcnt_reg    <= tcnt_next;
            pend_fl_reg <= pend_fl_next;
            mem_err_reg <= mem_err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        tcnt_next    = tcnt_reg;
        pend_fl_next = pend_fl_reg;
        mem_err_next = mem_err_reg;
        case (state_reg)
            HZ_RUN: begin
                if (mw) begin
                    state_next = HZ_MEM_WAIT;
                    tcnt_next  = TCNT_ONE;
                    // A redirect seen while memory stalls is replayed on the ready cycle.
                    if (ex_br_taken) begin
                        pend_fl_next = 1'b1;
                    end
                end
            end
            HZ_MEM_WAIT: begin
                if (!mem_ready) begin
                    if (tcnt_reg == TCNT_LIMIT) begin
                        state_next   = HZ_ERROR;
                        mem_err_next = 1'b1;
                    end else begin
                        tcnt_next = tcnt_reg + TCNT_ONE;
                    end
                end else begin
                    state_next   = HZ_RUN;
                    tcnt_next    = '0;
                    pend_fl_next = 1'b0;
                end
            end
            HZ_ERROR: begin
                state_next = HZ_ERROR;
            end
            default: begin
                state_next = HZ_RUN;
            end
        endcase
    end

    always_comb begin
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        stall_idex  = 1'b0;
        stall_exmem = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        if (!rst_n) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
        end else begin
            case (state_reg)
                HZ_RUN: begin
                    if (mw) begin
                        stall_pc    = 1'b1;
                        stall_ifid  = 1'b1;
                        stall_idex  = 1'b1;
                        stall_exmem = 1'b1;
                    end else if (ex_br_taken) begin
                        flush_ifid = 1'b1;
                        flush_idex = 1'b1;
                    end else if (lu) begin
                        stall_pc   = 1'b1;
                        stall_ifid = 1'b1;
                        flush_idex = 1'b1;
                    end
                end
                HZ_MEM_WAIT: begin
                    if (!mem_ready) begin
                        stall_pc    = 1'b1;
                        stall_ifid  = 1'b1;
                        stall_idex  = 1'b1;
                        stall_exmem = 1'b1;
                    end else if (pend_fl_reg) begin
                        flush_ifid = 1'b1;
                        flush_idex = 1'b1;
                    end
                end
                HZ_ERROR: begin
                    stall_pc    = 1'b1;
                    stall_ifid  = 1'b1;
                    stall_idex  = 1'b1;
                    stall_exmem = 1'b1;
                end
                default: begin
                    stall_pc = 1'b0;
                end
            endcase
        end
    end

    assign mem_err = mem_err_reg;

`ifdef HAZARD_CTRL_PERF_EN
    logic [2:0]        perf_inc;
    logic [PERF_W-1:0] perf_cnt [3];

    // perf_mw counts the cycles the memory wait actually holds the pipe.
    assign perf_inc[0] = rst_n && (state_reg == HZ_RUN) && lu;
    assign perf_inc[1] = rst_n && (((state_reg == HZ_RUN) && mw) ||
                                   ((state_reg == HZ_MEM_WAIT) && !mem_ready));
    assign perf_inc[2] = rst_n && flush_ifid;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_perf
            hazard_perf_cnt #(
                .PERF_W (PERF_W)
            ) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .inc   (perf_inc[gi]),
                .count (perf_cnt[gi])
            );
        end
    endgenerate

    assign perf_lu = perf_cnt[0];
    assign perf_mw = perf_cnt[1];
    assign perf_fl = perf_cnt[2];
`else
    assign perf_lu = '0;
    assign perf_mw = '0;
    assign perf_fl = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl: single-cycle vector table
// plus hand-written multi-cycle sequences (memory wait, timeout, reset, saturation).
module tb_hazard_ctrl;

`ifdef HAZARD_CTRL_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_memread, ex_br_taken, mem_req, mem_ready;

    logic        stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex, mem_err;
    logic [31:0] perf_lu, perf_mw, perf_fl;
    logic        s_stall_pc, s_stall_ifid, s_stall_idex, s_stall_exmem, s_flush_ifid, s_flush_idex, s_mem_err;
    logic [1:0]  s_perf_lu, s_perf_mw, s_perf_fl;

    logic [5:0] strb;
    assign strb = {stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex};

    int total = 0;
    int bad   = 0;

    hazard_ctrl #(.PERF_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_br_taken(ex_br_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
        .stall_exmem(stall_exmem), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .mem_err(mem_err), .perf_lu(perf_lu), .perf_mw(perf_mw), .perf_fl(perf_fl)
    );

    hazard_ctrl #(.PERF_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_br_taken(ex_br_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .stall_pc(s_stall_pc), .stall_ifid(s_stall_ifid), .stall_idex(s_stall_idex),
        .stall_exmem(s_stall_exmem), .flush_ifid(s_flush_ifid), .flush_idex(s_flush_idex),
        .mem_err(s_mem_err), .perf_lu(s_perf_lu), .perf_mw(s_perf_mw), .perf_fl(s_perf_fl)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       memread;
        logic       br;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = 5'd0; ex_memread = 1'b0; ex_br_taken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic set_lu();
        id_rs1 = 5'd5; id_use_rs1 = 1'b1; ex_rd = 5'd5; ex_memread = 1'b1;
    endtask

    initial begin
        // strobe order: stall_pc stall_ifid stall_idex stall_exmem flush_ifid flush_idex
        vecs[0] = '{rs1:5'd5, rs2:5'd0, u1:1'b1, u2:1'b0, rd:5'd5, memread:1'b1, br:1'b0, exp:6'b110001};
        vecs[1] = '{rs1:5'd5, rs2:5'd0, u1:1'b1, u2:1'b0, rd:5'd5, memread:1'b0, br:1'b0, exp:6'b000000};
        vecs[2] = '{rs1:5'd0, rs2:5'd0, u1:1'b1, u2:1'b0, rd:5'd0, memread:1'b1, br:1'b0, exp:6'b000000};
        vecs[3] = '{rs1:5'd1, rs2:5'd7, u1:1'b1, u2:1'b0, rd:5'd7, memread:1'b1, br:1'b0, exp:6'b000000};
        vecs[4] = '{rs1:5'd1, rs2:5'd7, u1:1'b1, u2:1'b1, rd:5'd7, memread:1'b1, br:1'b0, exp:6'b110001};
        vecs[5] = '{rs1:5'd9, rs2:5'd3, u1:1'b0, u2:1'b1, rd:5'd9, memread:1'b1, br:1'b0, exp:6'b000000};
        vecs[6] = '{rs1:5'd2, rs2:5'd3, u1:1'b1, u2:1'b1, rd:5'd4, memread:1'b0, br:1'b1, exp:6'b000011};
        vecs[7] = '{rs1:5'd5, rs2:5'd3, u1:1'b1, u2:1'b1, rd:5'd5, memread:1'b1, br:1'b1, exp:6'b000011};
        vecs[8] = '{rs1:5'd31, rs2:5'd31, u1:1'b1, u2:1'b1, rd:5'd31, memread:1'b1, br:1'b0, exp:6'b110001};

        idle();
        rst_n = 1'b0;
        #1;
        chk("reset_strobes", 32'(strb), 32'(6'b000011));
        step();
        chk("reset_mem_err", 32'(mem_err), 32'd0);
        chk("reset_perf_lu", perf_lu, 32'd0);
        chk("reset_perf_mw", perf_mw, 32'd0);
        chk("reset_perf_fl", perf_fl, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("idle_strobes", 32'(strb), 32'd0);
        step();

        for (int i = 0; i < 9; i++) begin
            id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
            id_use_rs1 = vecs[i].u1; id_use_rs2 = vecs[i].u2;
            ex_rd = vecs[i].rd; ex_memread = vecs[i].memread; ex_br_taken = vecs[i].br;
            #1;
            chk($sformatf("vec%0d_strobes", i), 32'(strb), 32'(vecs[i].exp));
            step();
        end

        // load-use then self-clear, then memory wait with deferred branch flush
        idle();
        do_reset();
        set_lu();
        #1;
        chk("lu_cycle", 32'(strb), 32'(6'b110001));
        step();
        ex_memread = 1'b0;
        #1;
        chk("lu_cleared", 32'(strb), 32'd0);
        step();
        idle();
        mem_req = 1'b1; mem_ready = 1'b0; ex_br_taken = 1'b1;
        #1;
        chk("mw_entry", 32'(strb), 32'(6'b111100));
        step();
        ex_br_taken = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            #1;
            chk($sformatf("mw_wait%0d", i), 32'(strb), 32'(6'b111100));
            step();
        end
        mem_ready = 1'b1;
        #1;
        chk("mw_ready_flush", 32'(strb), 32'(6'b000011));
        step();
        mem_req = 1'b0;
        #1;
        chk("mw_after_exit", 32'(strb), 32'd0);
        chk("perf_lu_t13", perf_lu, PERF_ON ? 32'd1 : 32'd0);
        chk("perf_mw_t13", perf_mw, PERF_ON ? 32'd4 : 32'd0);
        chk("perf_fl_t13", perf_fl, PERF_ON ? 32'd1 : 32'd0);

        // timeout into ERROR, then reset recovery
        idle();
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 200; i++) step();
        chk("to_pre_err", 32'(mem_err), 32'd0);
        chk("to_pre_strobes", 32'(strb), 32'(6'b111100));
        step();
        chk("to_mem_err", 32'(mem_err), 32'd1);
        mem_req = 1'b0; mem_ready = 1'b1;
        step();
        chk("err_hold_strobes", 32'(strb), 32'(6'b111100));
        chk("err_hold_mem_err", 32'(mem_err), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("err_reset_strobes", 32'(strb), 32'(6'b000011));
        step();
        rst_n = 1'b1;
        chk("err_reset_mem_err", 32'(mem_err), 32'd0);
        set_lu();
        #1;
        chk("err_reset_run_lu", 32'(strb), 32'(6'b110001));
        step();

        // reset during MEM_WAIT drops the pending flush
        idle();
        mem_req = 1'b1; mem_ready = 1'b0; ex_br_taken = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        ex_br_taken = 1'b0;
        step();
        mem_ready = 1'b1;
        #1;
        chk("no_stale_flush", 32'(strb), 32'd0);
        step();

        // saturation of a narrow counter
        idle();
        do_reset();
        set_lu();
        for (int i = 0; i < 5; i++) step();
        idle();
        #1;
        chk("perf_lu_wide", perf_lu, PERF_ON ? 32'd5 : 32'd0);
        chk("perf_lu_sat", 32'(s_perf_lu), PERF_ON ? 32'd3 : 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
